// File: rtl/cnt2_chk_pkg.sv
// rtl/cnt2_chk_pkg.sv - shared types and sequence helpers for cnt2_seq_checker (CNT2_CHK_GRAY_EN selects Gray order)
package cnt2_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACQ  = 2'b01,
    LOCK = 2'b10
  } state_t;

  // Entry i of the count order sits at bits [2i+1:2i]; entry 0 is the wrap target when counting up.
`ifdef CNT2_CHK_GRAY_EN
  localparam logic [7:0] SEQ_TABLE = {2'b10, 2'b11, 2'b01, 2'b00};
`else
  localparam logic [7:0] SEQ_TABLE = {2'b11, 2'b10, 2'b01, 2'b00};
`endif

  function automatic logic [1:0] seq_at(input logic [1:0] idx);
    return SEQ_TABLE[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic [1:0] seq_pos(input logic [1:0] val);
    logic [1:0] pos;
    pos = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (seq_at(2'(i)) == val) pos = 2'(i);
    end
    return pos;
  endfunction

  // Value expected after cur when moving in the given direction.
  function automatic logic [1:0] step(input logic [1:0] cur, input logic up);
    logic [1:0] pos;
    pos = seq_pos(cur);
    return up ? seq_at(pos + 2'd1) : seq_at(pos - 2'd1);
  endfunction

  // True when prev -> cur crosses the sequence boundary in the given direction.
  function automatic logic is_wrap(input logic [1:0] prev, input logic [1:0] cur, input logic up);
    if (up) return (prev == seq_at(2'd3)) && (cur == seq_at(2'd0));
    else    return (prev == seq_at(2'd0)) && (cur == seq_at(2'd3));
  endfunction

endpackage

// File: rtl/cnt2_step_calc.sv
// rtl/cnt2_step_calc.sv - combinational expected-next and wrap detection (order set by CNT2_CHK_GRAY_EN)
module cnt2_step_calc
  import cnt2_chk_pkg::*;
(
  input  logic [1:0] i_last_q,
  input  logic [1:0] i_q,
  input  logic       i_up,
  output logic [1:0] o_nx,
  output logic       o_wrap
);

  // Pure lookup against the package sequence table.
  always_comb begin
    o_nx   = step(i_last_q, i_up);
    o_wrap = is_wrap(i_last_q, i_q, i_up);
  end

endmodule

// File: rtl/cnt2_seq_checker.sv
// rtl/cnt2_seq_checker.sv - 2-bit counter sequence checker with lock, error and wrap counters (CNT2_CHK_GRAY_EN selects Gray order)
module cnt2_seq_checker
  import cnt2_chk_pkg::*;
#(
  parameter int WRAP_W   = 8,
  parameter int ERR_W    = 4,
  parameter int LOCK_CNT = 2
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [1:0]        q,
  input  logic              en,
  input  logic              up,
  output logic              locked,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [1:0]        last_q
);

  localparam int              GR_W      = $clog2(LOCK_CNT + 1);
  localparam logic [GR_W-1:0] LAST_GOOD = GR_W'(LOCK_CNT - 1);

  state_t            r_state;
  state_t            w_state_nx;
  logic [GR_W-1:0]   r_good_run;
  logic [GR_W-1:0]   w_good_run_nx;
  logic [1:0]        r_last_q;
  logic              r_err;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic [1:0]        w_nx;
  logic              w_wrap;
  logic              w_match;
  logic              w_stall;
  logic              w_err_nx;
  logic              w_wrap_inc;

  cnt2_step_calc u_step_calc (
    .i_last_q (r_last_q),
    .i_q      (q),
    .i_up     (up),
    .o_nx     (w_nx),
    .o_wrap   (w_wrap)
  );

  assign w_match = (q == w_nx);
  assign w_stall = (q == r_last_q);

  // State register; clears together with the upstream counter.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  // Next state: only enabled samples move the FSM.
  always_comb begin
    w_state_nx = r_state;
    if (en) begin
      case (r_state)
        IDLE:    w_state_nx = ACQ;
        ACQ:     if (w_match && (r_good_run == LAST_GOOD)) w_state_nx = LOCK;
        LOCK:    if (!w_match && !w_stall) w_state_nx = ACQ;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // Per-sample actions: good-run bookkeeping, error pulse and wrap increment.
  always_comb begin
    w_good_run_nx = r_good_run;
    w_err_nx      = 1'b0;
    w_wrap_inc    = 1'b0;
    if (en) begin
      case (r_state)
        IDLE: w_good_run_nx = '0;
        ACQ: begin
          if (w_match)       w_good_run_nx = r_good_run + GR_W'(1);
          else if (!w_stall) w_good_run_nx = '0;
        end
        LOCK: begin
          if (w_match) begin
            w_wrap_inc = w_wrap;
          end else if (!w_stall) begin
            w_err_nx      = 1'b1;
            w_good_run_nx = '0;
          end
        end
        default: w_good_run_nx = '0;
      endcase
    end
  end

  // Datapath registers; err is rewritten every edge so it lasts one clock.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_good_run <= '0;
      r_last_q   <= 2'b00;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_wrap_cnt <= '0;
    end else begin
      r_err <= w_err_nx;
      if (en) begin
        r_last_q   <= q;
        r_good_run <= w_good_run_nx;
      end
      if (w_err_nx && (r_err_cnt != {ERR_W{1'b1}})) r_err_cnt <= r_err_cnt + ERR_W'(1);
      if (w_wrap_inc) r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
    end
  end

  assign locked   = (r_state == LOCK);
  assign err      = r_err;
  assign err_cnt  = r_err_cnt;
  assign wrap_cnt = r_wrap_cnt;
  assign last_q   = r_last_q;

endmodule
